ibuffer_warp: RTL and testbench

Per-warp instruction buffer sitting between decode and the issue arbiter, acting as the initiator side of the per-warp scoreboard interface. It queues decoded instructions, presents the head instruction's register IDs to the scoreboard, raises an issue request only when the scoreboard reports no hazard and free space, and forwards the arbiter grant as the scoreboard allocation strobe. It also owns the single-entry LW/SW replay slot: it re-issues replays without new scoreboard allocation and signals replay completion back to the scoreboard.

---
 rtl/ibuffer_warp.sv | 189 ++++++++++++++++++
 tb/tb_ibuffer_warp.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibuffer_warp.sv
// Per-warp instruction FIFO with a single-entry LW/SW replay slot.
// Optional IBUF_FLUSH_EN adds a flush port that empties the FIFO.
module ibuffer_warp #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dep_valid,
  input  logic [4:0]           dep_src1,
  input  logic [4:0]           dep_src2,
  input  logic [4:0]           dep_dst,
  input  logic                 dep_src1_valid,
  input  logic                 dep_src2_valid,
  input  logic                 dep_dst_valid,
  input  logic                 dep_replayable,
  input  logic                 dep_SW_LWbar,
  input  logic [PAYLOAD_W-1:0] dep_payload,
  output logic                 ibuf_full,
  output logic [4:0]           src1,
  output logic [4:0]           src2,
  output logic [4:0]           dst,
  output logic                 src1_valid,
  output logic                 src2_valid,
  output logic                 dst_valid,
  output logic                 replayable,
  output logic                 RP_grt,
  input  logic                 full_Scb,
  input  logic                 dependent_Scb,
  input  logic [1:0]           ScbID_Scb,
  output logic                 replay_complete,
  output logic [1:0]           replay_complete_ScbID,
  output logic                 replay_SW_LWbar,
  output logic                 issue_req,
  input  logic                 issue_grt,
  output logic [PAYLOAD_W-1:0] issue_payload,
  output logic [1:0]           issue_ScbID,
  output logic                 issue_is_replay,
  input  logic                 mem_replay,
  input  logic                 mem_done,
`ifdef IBUF_FLUSH_EN
  input  logic                 flush,
`endif
  output logic                 empty_IB
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = PAYLOAD_W + 20;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic [EW-1:0]        mem_q [DEPTH];
  logic [AW-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [1:0]           st_q, st_d;
  logic [PAYLOAD_W-1:0] spl_q, spl_d;
  logic [1:0]           sid_q, sid_d;
  logic                 ssw_q, ssw_d;
  logic                 rc_q, rc_d;
  logic [1:0]           rcid_q, rcid_d;
  logic                 rcsw_q, rcsw_d;

  logic          flush_w;
  logic          hv, replay_sel, head_ok;
  logic          push, pop;
  logic [EW-1:0] head;
  logic [EW-1:0] dep_ent;

`ifdef IBUF_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign dep_ent = {dep_payload, dep_SW_LWbar, dep_replayable,
                    dep_dst_valid, dep_src2_valid, dep_src1_valid,
                    dep_dst, dep_src2, dep_src1};

  assign head = mem_q[rd_q];
  assign hv   = (cnt_q != '0);

  assign src1       = head[4:0];
  assign src2       = head[9:5];
  assign dst        = head[14:10];
  assign src1_valid = hv & head[15];
  assign src2_valid = hv & head[16];
  assign dst_valid  = hv & head[17];
  assign replayable = hv & head[18];

  assign ibuf_full  = (cnt_q == FULL_CNT);
  assign empty_IB   = !hv && (st_q == S_FREE);
  assign replay_sel = (st_q == S_PEND);

  assign head_ok = hv & !full_Scb & !dependent_Scb
                 & !(head[18] & (st_q != S_FREE));

  assign issue_req = (replay_sel | head_ok) & !flush_w;
  assign RP_grt    = issue_grt & !replay_sel;

  assign issue_payload   = replay_sel ? spl_q : head[EW-1:20];
  assign issue_ScbID     = replay_sel ? sid_q : ScbID_Scb;
  assign issue_is_replay = replay_sel;

  assign replay_complete       = rc_q;
  assign replay_complete_ScbID = rcid_q;
  assign replay_SW_LWbar       = rcsw_q;

  assign pop  = issue_grt & !replay_sel & hv & !flush_w;
  assign push = dep_valid & (!ibuf_full | pop) & !flush_w;

  always_comb begin
    rd_d  = pop  ? rd_q + AW'(1) : rd_q;
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (flush_w) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  always_comb begin
    st_d   = st_q;
    spl_d  = spl_q;
    sid_d  = sid_q;
    ssw_d  = ssw_q;
    rc_d   = 1'b0;
    rcid_d = rcid_q;
    rcsw_d = rcsw_q;
    unique case (st_q)
      S_FREE: if (pop && head[18]) begin
        st_d  = S_WAIT;
        spl_d = head[EW-1:20];
        sid_d = ScbID_Scb;
        ssw_d = head[19];
      end
      // mem_done takes priority over a simultaneous replay request
      S_WAIT: if (mem_done) begin
        st_d   = S_FREE;
        rc_d   = 1'b1;
        rcid_d = sid_q;
        rcsw_d = ssw_q;
      end else if (mem_replay) begin
        st_d = S_PEND;
      end
      S_PEND: if (issue_grt && !flush_w) st_d = S_WAIT;
      default: st_d = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= dep_ent;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      st_q   <= S_FREE;
      spl_q  <= '0;
      sid_q  <= '0;
      ssw_q  <= 1'b0;
      rc_q   <= 1'b0;
      rcid_q <= '0;
      rcsw_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      spl_q  <= spl_d;
      sid_q  <= sid_d;
      ssw_q  <= ssw_d;
      rc_q   <= rc_d;
      rcid_q <= rcid_d;
      rcsw_q <= rcsw_d;
    end
  end

endmodule

// File: tb/tb_ibuffer_warp.sv
// Directed bench for ibuffer_warp with a payload scoreboard queue.
// Flush steps build only when IBUF_FLUSH_EN is defined.
module tb_ibuffer_warp;

  logic        clk = 1'b0;
  logic        rst;
  logic        dep_valid;
  logic [4:0]  dep_src1, dep_src2, dep_dst;
  logic        dep_src1_valid, dep_src2_valid, dep_dst_valid;
  logic        dep_replayable, dep_SW_LWbar;
  logic [31:0] dep_payload;
  logic        ibuf_full;
  logic [4:0]  src1, src2, dst;
  logic        src1_valid, src2_valid, dst_valid, replayable;
  logic        RP_grt;
  logic        full_Scb, dependent_Scb;
  logic [1:0]  ScbID_Scb;
  logic        replay_complete;
  logic [1:0]  replay_complete_ScbID;
  logic        replay_SW_LWbar;
  logic        issue_req, issue_grt;
  logic [31:0] issue_payload;
  logic [1:0]  issue_ScbID;
  logic        issue_is_replay;
  logic        mem_replay, mem_done;
  logic        empty_IB;
`ifdef IBUF_FLUSH_EN
  logic        flush;
`endif

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] exp_q [$];
  logic [31:0] lw_pl;

  ibuffer_warp #(.DEPTH(4), .PAYLOAD_W(32)) dut (
    .clk(clk), .rst(rst),
    .dep_valid(dep_valid),
    .dep_src1(dep_src1), .dep_src2(dep_src2), .dep_dst(dep_dst),
    .dep_src1_valid(dep_src1_valid),
    .dep_src2_valid(dep_src2_valid),
    .dep_dst_valid(dep_dst_valid),
    .dep_replayable(dep_replayable),
    .dep_SW_LWbar(dep_SW_LWbar),
    .dep_payload(dep_payload),
    .ibuf_full(ibuf_full),
    .src1(src1), .src2(src2), .dst(dst),
    .src1_valid(src1_valid), .src2_valid(src2_valid),
    .dst_valid(dst_valid), .replayable(replayable),
    .RP_grt(RP_grt),
    .full_Scb(full_Scb), .dependent_Scb(dependent_Scb),
    .ScbID_Scb(ScbID_Scb),
    .replay_complete(replay_complete),
    .replay_complete_ScbID(replay_complete_ScbID),
    .replay_SW_LWbar(replay_SW_LWbar),
    .issue_req(issue_req), .issue_grt(issue_grt),
    .issue_payload(issue_payload),
    .issue_ScbID(issue_ScbID),
    .issue_is_replay(issue_is_replay),
    .mem_replay(mem_replay), .mem_done(mem_done),
`ifdef IBUF_FLUSH_EN
    .flush(flush),
`endif
    .empty_IB(empty_IB)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Sets up a deposit; caller ticks and clears dep_valid.
  task automatic set_dep(input logic [31:0] p, input logic repl,
                         input logic sw);
    dep_valid      = 1'b1;
    dep_src1       = p[4:0];
    dep_src2       = p[9:5];
    dep_dst        = p[14:10];
    dep_src1_valid = 1'b1;
    dep_src2_valid = 1'b0;
    dep_dst_valid  = 1'b1;
    dep_replayable = repl;
    dep_SW_LWbar   = sw;
    dep_payload    = p;
    exp_q.push_back(p);
  endtask

  task automatic dep1(input logic [31:0] p, input logic repl,
                      input logic sw);
    set_dep(p, repl, sw);
    tick();
    dep_valid = 1'b0;
  endtask

  // Grants the head in the current cycle and checks against the queue.
  task automatic grant_head(input string tag, input logic [1:0] id);
    logic [31:0] e;
    ScbID_Scb = id;
    issue_grt = 1'b1;
    #1;
    chk({tag, "_rpgrt"}, RP_grt, 1'b1);
    chk({tag, "_scbid"}, issue_ScbID, id);
    chk({tag, "_isrep"}, issue_is_replay, 1'b0);
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_pl"}, issue_payload, e);
    end
    tick();
    issue_grt = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    dep_valid = 1'b0;
    dep_src1 = '0; dep_src2 = '0; dep_dst = '0;
    dep_src1_valid = 1'b0; dep_src2_valid = 1'b0;
    dep_dst_valid = 1'b0;
    dep_replayable = 1'b0; dep_SW_LWbar = 1'b0;
    dep_payload = '0;
    full_Scb = 1'b0; dependent_Scb = 1'b0;
    ScbID_Scb = '0;
    issue_grt = 1'b0;
    mem_replay = 1'b0; mem_done = 1'b0;
`ifdef IBUF_FLUSH_EN
    flush = 1'b0;
`endif

    tick();
    tick();
    chk("rst_full", ibuf_full, 1'b0);
    chk("rst_req", issue_req, 1'b0);
    chk("rst_rpgrt", RP_grt, 1'b0);
    chk("rst_rc", replay_complete, 1'b0);
    chk("rst_empty", empty_IB, 1'b1);
    chk("rst_s1v", src1_valid, 1'b0);
    chk("rst_dstv", dst_valid, 1'b0);
    rst = 1'b1;
    tick();

    // Four independent ALU ops, then drain with grant held high
    dep1(32'h1111_0421, 1'b0, 1'b0);
    chk("t1_head_vis", issue_req, 1'b1);
    chk("t1_s1", src1, 5'h01);
    chk("t1_s1v", src1_valid, 1'b1);
    chk("t1_s2v", src2_valid, 1'b0);
    dep1(32'h2222_0842, 1'b0, 1'b0);
    dep1(32'h3333_0c63, 1'b0, 1'b0);
    chk("t1_notfull3", ibuf_full, 1'b0);
    dep1(32'h4444_1084, 1'b0, 1'b0);
    #1;
    chk("t1_full", ibuf_full, 1'b1);
    chk("t1_req", issue_req, 1'b1);
    for (int i = 0; i < 4; i++) grant_head("t1_drain", 2'(i));
    #1;
    chk("t1_empty", empty_IB, 1'b1);
    chk("t1_req_off", issue_req, 1'b0);
    chk("t1_full_off", ibuf_full, 1'b0);

    // Dependency stall for three cycles
    dep1(32'h5555_14a5, 1'b0, 1'b0);
    dependent_Scb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_stall", issue_req, 1'b0);
      tick();
    end
    dependent_Scb = 1'b0;
    #1;
    chk("t2_req", issue_req, 1'b1);
    grant_head("t2_go", 2'd1);

    // Scoreboard full also blocks
    dep1(32'h5656_0001, 1'b0, 1'b0);
    full_Scb = 1'b1;
    #1;
    chk("t2b_fullscb", issue_req, 1'b0);
    full_Scb = 1'b0;
    #1;
    grant_head("t2b_go", 2'd0);

    // LW: issue, replay, complete
    lw_pl = 32'h6666_18c6;
    dep1(lw_pl, 1'b1, 1'b0);
    #1;
    chk("t3_repl_flag", replayable, 1'b1);
    grant_head("t3_lw", 2'd2);
    #1;
    chk("t3_wait_req", issue_req, 1'b0);
    chk("t3_wait_empty", empty_IB, 1'b0);
    mem_replay = 1'b1;
    tick();
    mem_replay = 1'b0;
    ScbID_Scb = 2'd3;
    #1;
    chk("t3_pend_req", issue_req, 1'b1);
    chk("t3_pend_isrep", issue_is_replay, 1'b1);
    chk("t3_pend_id", issue_ScbID, 2'd2);
    chk("t3_pend_pl", issue_payload, lw_pl);
    issue_grt = 1'b1;
    #1;
    chk("t3_rep_rpgrt", RP_grt, 1'b0);
    tick();
    issue_grt = 1'b0;
    #1;
    chk("t3_back_wait", issue_req, 1'b0);
    chk("t3_no_rc", replay_complete, 1'b0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    #1;
    chk("t3_rc", replay_complete, 1'b1);
    chk("t3_rc_id", replay_complete_ScbID, 2'd2);
    chk("t3_rc_sw", replay_SW_LWbar, 1'b0);
    chk("t3_rc_empty", empty_IB, 1'b1);
    tick();
    chk("t3_rc_pulse", replay_complete, 1'b0);

    // mem_* ignored while slot is free
    mem_replay = 1'b1;
    mem_done   = 1'b1;
    tick();
    mem_replay = 1'b0;
    mem_done   = 1'b0;
    #1;
    chk("t3_ign_rc", replay_complete, 1'b0);
    chk("t3_ign_req", issue_req, 1'b0);

    // SW in WAIT blocks a following LW at the head
    dep1(32'h7777_1ce7, 1'b1, 1'b1);
    grant_head("t4_sw", 2'd1);
    dep1(32'h8888_2108, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t4_lw_block", issue_req, 1'b0);
      tick();
    end
    // done and replay together: done wins
    mem_done   = 1'b1;
    mem_replay = 1'b1;
    tick();
    mem_done   = 1'b0;
    mem_replay = 1'b0;
    #1;
    chk("t4_rc", replay_complete, 1'b1);
    chk("t4_rc_id", replay_complete_ScbID, 2'd1);
    chk("t4_rc_sw", replay_SW_LWbar, 1'b1);
    chk("t4_no_pend", issue_is_replay, 1'b0);
    tick();
    chk("t4_lw_req", issue_req, 1'b1);
    grant_head("t4_lw", 2'd3);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    #1;
    chk("t4_lw_rc_id", replay_complete_ScbID, 2'd3);

    // Wrap-around: full FIFO with deposit and pop every cycle
    for (int i = 0; i < 4; i++) dep1(32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t5_full", ibuf_full, 1'b1);
      set_dep(32'hB000_0000 + 32'(i), 1'b0, 1'b0);
      grant_head("t5_wrap", 2'(i));
      dep_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) grant_head("t5_drain", 2'd0);
    #1;
    chk("t5_empty", empty_IB, 1'b1);

`ifdef IBUF_FLUSH_EN
    dep1(32'hC000_0001, 1'b1, 1'b0);
    grant_head("t6_lw", 2'd1);
    for (int i = 0; i < 3; i++) dep1(32'hD000_0000 + 32'(i), 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("t6_flush_req", issue_req, 1'b0);
    tick();
    flush = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_fifo_empty", src1_valid, 1'b0);
    chk("t6_full_off", ibuf_full, 1'b0);
    chk("t6_slot_busy", empty_IB, 1'b0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    #1;
    chk("t6_rc", replay_complete, 1'b1);
    chk("t6_rc_id", replay_complete_ScbID, 2'd1);
    chk("t6_empty", empty_IB, 1'b1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
